// File: rtl/seq_multdiv_unit.sv
// seq_multdiv_unit: multicycle signed multiply (radix-2 Booth) / divide (restoring) unit
// with registered result, exception flag, one-cycle ready strobe and busy flag.
module seq_multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi, lo, mcand;
    logic             q_m1, neg, ovf;
    logic [WIDTH:0]   booth_sum, shifted, diff;
    logic [WIDTH-1:0] abs_a, abs_b, quot;
    logic             fits, last, prod_ovf;

    // Booth sum is one bit wider so a MIN multiplicand cannot overflow the partial product;
    // the final product's top WIDTH+1 bits are exactly this sum.
    always_comb begin
        abs_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        abs_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        booth_sum = (lo[0] == q_m1) ? {hi[WIDTH-1], hi} :
                    lo[0] ? {hi[WIDTH-1], hi} - {mcand[WIDTH-1], mcand} :
                            {hi[WIDTH-1], hi} + {mcand[WIDTH-1], mcand};
        prod_ovf  = |booth_sum && !(&booth_sum);
        shifted   = {hi, lo[WIDTH-1]};
        diff      = shifted - {1'b0, mcand};
        fits      = !diff[WIDTH];
        quot      = neg ? -lo : lo;
        last      = cnt == CNT_W'(WIDTH-1);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            cnt            <= '0;
            hi             <= '0;
            lo             <= '0;
            mcand          <= '0;
            q_m1           <= 1'b0;
            neg            <= 1'b0;
            ovf            <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                MUL: begin
                    hi   <= booth_sum[WIDTH:1];
                    lo   <= {booth_sum[0], lo[WIDTH-1:1]};
                    q_m1 <= lo[0];
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        state          <= DONE;
                        busy           <= 1'b0;
                        data_resultRDY <= 1'b1;
                        data_result    <= {booth_sum[0], lo[WIDTH-1:1]};
                        data_exception <= prod_ovf;
                    end
                end
                DIV: begin
                    hi  <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    lo  <= {lo[WIDTH-2:0], fits};
                    cnt <= cnt + 1'b1;
                    if (last)
                        state <= FIX;
                end
                FIX: begin
                    state          <= DONE;
                    busy           <= 1'b0;
                    data_resultRDY <= 1'b1;
                    data_result    <= quot;
                    data_exception <= ovf;
                end
                default: begin
                    cnt <= '0;
                    if (ctrl_MULT) begin
                        state <= MUL;
                        busy  <= 1'b1;
                        hi    <= '0;
                        lo    <= data_operandB;
                        q_m1  <= 1'b0;
                        mcand <= data_operandA;
                    end else if (ctrl_DIV && data_operandB == '0) begin
                        state          <= DONE;
                        data_resultRDY <= 1'b1;
                        data_result    <= '0;
                        data_exception <= 1'b1;
                    end else if (ctrl_DIV) begin
                        state <= DIV;
                        busy  <= 1'b1;
                        hi    <= '0;
                        lo    <= abs_a;
                        mcand <= abs_b;
                        neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        ovf   <= data_operandA == MIN && data_operandB == '1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_multdiv_unit.sv
// tb_seq_multdiv_unit: scoreboard bench for seq_multdiv_unit; expectations come from
// plain integer arithmetic and are popped by an independent monitor on each ready strobe.
module tb_seq_multdiv_unit;
    localparam int W = 32;

    logic         clock = 1'b0;
    logic         resetn;
    logic [W-1:0] data_operandA = '0, data_operandB = '0;
    logic         ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
    logic [W-1:0] data_result;
    logic         data_exception, data_resultRDY, busy;

    logic [7:0]   a8 = '0, b8 = '0, res8;
    logic         m8 = 1'b0, d8 = 1'b0, exc8, rdy8, busy8;

    seq_multdiv_unit #(.WIDTH(W)) dut (
        .clock(clock), .resetn(resetn),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_result(data_result), .data_exception(data_exception),
        .data_resultRDY(data_resultRDY), .busy(busy)
    );

    seq_multdiv_unit #(.WIDTH(8)) dut8 (
        .clock(clock), .resetn(resetn),
        .data_operandA(a8), .data_operandB(b8),
        .ctrl_MULT(m8), .ctrl_DIV(d8),
        .data_result(res8), .data_exception(exc8),
        .data_resultRDY(rdy8), .busy(busy8)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         exc;
        int           at;
    } exp_t;

    exp_t sb[$];
    int checks = 0, errors = 0;

    function automatic exp_t model(bit m, logic [W-1:0] a, logic [W-1:0] b, int now);
        exp_t   e;
        int     sa = a;
        int     sbv = b;
        longint p;
        if (m) begin
            p     = longint'(sa) * longint'(sbv);
            e.res = p[W-1:0];
            e.exc = p > 64'sd2147483647 || p < -64'sd2147483648;
            e.at  = now + 1 + W;
        end else if (sbv == 0) begin
            e.res = '0;
            e.exc = 1'b1;
            e.at  = now + 1;
        end else if (a == 32'h8000_0000 && sbv == -1) begin
            e.res = 32'h8000_0000;
            e.exc = 1'b1;
            e.at  = now + 2 + W;
        end else begin
            e.res = sa / sbv;
            e.exc = 1'b0;
            e.at  = now + 2 + W;
        end
        return e;
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (resetn && data_resultRDY) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rdy result=%h exc=%b cycle=%0d", data_result, data_exception, cyc);
            end else begin
                e = sb.pop_front();
                if (data_result !== e.res || data_exception !== e.exc || cyc != e.at) begin
                    errors++;
                    $display("FAIL completion got res=%h exc=%b cycle=%0d expected res=%h exc=%b cycle=%0d",
                             data_result, data_exception, cyc, e.res, e.exc, e.at);
                end
            end
        end
    end

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic go(bit m, bit d, logic [W-1:0] a, logic [W-1:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        if (m || d)
            sb.push_back(model(m, a, b, cyc));
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (!data_resultRDY && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!data_resultRDY) begin
            checks++;
            errors++;
            $display("FAIL rdy_timeout got no ready expected ready within 100 cycles");
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7fff_ffff;
            4:       return 32'($urandom_range(0, 40)) - 32'd20;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int c0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #10;
        chk("reset_result", data_result, '0);
        chk("reset_exc", W'(data_exception), '0);
        chk("reset_rdy", W'(data_resultRDY), '0);
        chk("reset_busy", W'(busy), '0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        go(1, 0, 7, -3); wait_rdy(); @(negedge clock);
        go(1, 0, 32'h10000, 32'h10000); wait_rdy();
        go(1, 0, -1, -1); wait_rdy(); @(negedge clock);
        go(0, 1, -7, 2); wait_rdy();
        go(0, 1, 32'h8000_0000, -1); wait_rdy(); @(negedge clock);
        go(0, 1, 5, 0); wait_rdy(); @(negedge clock);

        go(0, 1, 100, 7);
        repeat (3) @(negedge clock);
        chk("busy_in_flight", W'(busy), 1);
        data_operandB = '0;
        ctrl_DIV = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        wait_rdy();
        @(negedge clock);
        chk("busy_after_done", W'(busy), 0);

        go(1, 1, 6, 3); wait_rdy();
        go(0, 1, 100, 3);
        chk("result_held_on_start", data_result, 18);
        wait_rdy();

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) != 0)
                repeat ($urandom_range(1, 3)) @(negedge clock);
            go($urandom_range(0, 1) == 1, 1'b1, pick(), pick());
            wait_rdy();
        end

        @(negedge clock);
        go(1, 0, 123, 456);
        repeat (9) @(negedge clock);
        #2 resetn = 1'b0;
        sb.delete();
        #1;
        chk("abort_result", data_result, '0);
        chk("abort_exc", W'(data_exception), '0);
        chk("abort_rdy", W'(data_resultRDY), '0);
        chk("abort_busy", W'(busy), '0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (40) @(negedge clock);
        go(1, 0, -5, 9); wait_rdy(); @(negedge clock);

        a8 = 8'd12;
        b8 = 8'hF5;
        m8 = 1'b1;
        c0 = cyc;
        @(negedge clock);
        m8 = 1'b0;
        n = 0;
        while (!rdy8 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("w8_rdy", W'(rdy8), 1);
        chk("w8_result", W'(res8), 32'h7C);
        chk("w8_exc", W'(exc8), 1);
        chk("w8_latency", W'(cyc - c0 - 1), 8);

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", W'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
